// File: rtl/instruction_fetch_unit.sv
// Fetch front end: PC register, one imem read per cycle, {pc, instr} FIFO drained by decode over valid/ready.
// Optional macro IFU_MISALIGN_TRAP_EN: a misaligned redirect sets sticky misalign_err and halts fetch until reset.
module instruction_fetch_unit #(
  parameter int               Width    = 32,
  parameter logic [Width-1:0] RESET_PC = {Width{1'b0}},
  parameter int               QDEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_en,
  output logic [Width-1:0] imem_addr,
  input  logic [Width-1:0] imem_rd,
  input  logic             redirect_valid,
  input  logic [Width-1:0] redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [Width-1:0] inst_out,
  output logic [Width-1:0] inst_pc,
  output logic             misalign_err
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] full_count_c = CW'(QDEPTH);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t           state_r;
  logic [Width-1:0] fetch_pc_r;
  logic [Width-1:0] pc_mem_r  [QDEPTH];
  logic [Width-1:0] ins_mem_r [QDEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             valid_r;
  logic             misalign_r;

  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             misalign_s;
  logic [CW-1:0]    count_s;
  logic [Width-1:0] target_s;

  // Handshake, push decision, next occupancy and redirect target
  always_comb begin
    pop_s  = valid_r & inst_ready;
    full_s = (count_r == full_count_c);
    push_s = fetch_en & ~redirect_valid & (state_r == RUN) & (~full_s | pop_s);
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CW'(1);
      2'b01:   count_s = count_r - CW'(1);
      default: count_s = count_r;
    endcase
`ifdef IFU_MISALIGN_TRAP_EN
    target_s   = redirect_pc;
    misalign_s = redirect_valid & (redirect_pc[1:0] != 2'b00);
`else
    target_s   = redirect_pc & {{(Width-2){1'b1}}, 2'b00};
    misalign_s = 1'b0;
`endif
  end

  // PC, FIFO storage/pointers and RUN/HALT state; redirect outranks push
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= RUN;
      fetch_pc_r <= RESET_PC;
      rd_ptr_r   <= {AW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      valid_r    <= 1'b0;
      misalign_r <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
        pc_mem_r[i]  <= {Width{1'b0}};
        ins_mem_r[i] <= {Width{1'b0}};
      end
    end else if (redirect_valid) begin
      rd_ptr_r   <= {AW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      valid_r    <= 1'b0;
      fetch_pc_r <= target_s;
      if (misalign_s) begin
        misalign_r <= 1'b1;
        state_r    <= HALT;
      end
    end else begin
      if (push_s) begin
        pc_mem_r[wr_ptr_r]  <= fetch_pc_r;
        ins_mem_r[wr_ptr_r] <= imem_rd;
        wr_ptr_r            <= wr_ptr_r + AW'(1);
        fetch_pc_r          <= fetch_pc_r + Width'(4);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_s;
      valid_r <= (count_s != {CW{1'b0}});
    end
  end

  assign imem_addr    = fetch_pc_r;
  assign inst_valid   = valid_r;
  assign inst_out     = ins_mem_r[rd_ptr_r];
  assign inst_pc      = pc_mem_r[rd_ptr_r];
  assign misalign_err = misalign_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed scenarios followed by randomized traffic.
module tb_instruction_fetch_unit;

  localparam int QDEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        misalign_err;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] exp_q[$];
  logic [31:0] mpc   = RESET_PC;
  logic        mhalt = 1'b0;
  logic        merr  = 1'b0;

  instruction_fetch_unit #(.Width(32), .RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .imem_addr(imem_addr), .imem_rd(imem_rd),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc), .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0020_81B3;
    else if (a == 32'h0000_0004) return 32'h4032_02B3;
    else return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign imem_rd = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the expected FIFO contents as a queue of {pc, instr}
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      mpc   <= RESET_PC;
      mhalt <= 1'b0;
      merr  <= 1'b0;
    end else if (redirect_valid) begin
      exp_q.delete();
`ifdef IFU_MISALIGN_TRAP_EN
      mpc <= redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        mhalt <= 1'b1;
        merr  <= 1'b1;
      end
`else
      mpc <= redirect_pc & 32'hFFFF_FFFC;
`endif
    end else if (fetch_en && !mhalt && exp_q.size() < QDEPTH) begin
      exp_q.push_back({mpc, mem_word(mpc)});
      mpc <= mpc + 32'd4;
    end
  end

  // Monitor: compare presented head and consume it on a completed handshake
  always @(negedge clk) begin
    logic [63:0] head;
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, (exp_q.size() != 0)});
    chk("imem_addr", imem_addr, mpc);
    chk("misalign_err", {31'd0, misalign_err}, {31'd0, merr});
    if (inst_valid && exp_q.size() != 0) begin
      head = exp_q[0];
      chk("inst_pc", inst_pc, head[63:32]);
      chk("inst_out", inst_out, head[31:0]);
      if (inst_ready && rst_n) void'(exp_q.pop_front());
    end
  end

  task automatic drive(input logic r, input logic fe, input logic rdy, input logic rv,
                       input logic [31:0] rpc, input int n);
    for (int i = 0; i < n; i++) begin
      rst_n          = r;
      fetch_en       = fe;
      inst_ready     = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2);
    chk("reset_valid", {31'd0, inst_valid}, 32'd0);
    chk("reset_addr", imem_addr, RESET_PC);
    chk("reset_out", inst_out, 32'd0);
    chk("reset_pc", inst_pc, 32'd0);

    // Streaming with decode always ready
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 8);

    // Back-pressure saturates the FIFO
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 10);
    chk("sat_addr", imem_addr, 32'h0000_0010);
    chk("sat_head", inst_pc, 32'h0000_0000);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 8);

    // Redirect with three entries buffered
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 3);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0030, 1);
    chk("redir_flush", {31'd0, inst_valid}, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1);
    chk("redir_first", inst_pc, 32'h0000_0030);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 5);

    // Redirect coinciding with a pop while full
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 6);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 1);
    chk("redir_pop_pc", imem_addr, 32'h0000_0100);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 4);

    // Misaligned redirect
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0032, 1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 5);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1);

    // PC wrap and mid-stream reset
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 2);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1);
    chk("midrst_valid", {31'd0, inst_valid}, 32'd0);
    chk("midrst_addr", imem_addr, RESET_PC);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = $urandom;
      if ($urandom_range(0, 3) != 0) tgt = tgt & 32'hFFFF_FFFC;
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 8),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0), tgt, 1);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
